// File: rtl/jtframe_cen_ctrl_if.sv
// Configuration and clock-enable bundle for jtframe_cen_ctrl.
// The step input exists only when JTFRAME_CEN_STEP_EN is defined.
interface jtframe_cen_ctrl_if #(
  parameter int unsigned W = 11
);
  logic [W-1:0] cfg_num;
  logic [W-1:0] cfg_den;
  logic         cfg_req;
  logic         cfg_ack;
  logic         cfg_err;
  logic         pause;
`ifdef JTFRAME_CEN_STEP_EN
  logic         step;
`endif
  logic         cen;
  logic         cen_half;
  logic         busy;

  modport master (
`ifdef JTFRAME_CEN_STEP_EN
    output step,
`endif
    output cfg_num, cfg_den, cfg_req, pause,
    input  cfg_ack, cfg_err, cen, cen_half, busy
  );

  modport slave (
`ifdef JTFRAME_CEN_STEP_EN
    input  step,
`endif
    input  cfg_num, cfg_den, cfg_req, pause,
    output cfg_ack, cfg_err, cen, cen_half, busy
  );
endinterface

// File: rtl/jtframe_cen_ctrl.sv
// Runtime-programmable fractional cen generator (rate clk*num/den) with pulse-aligned ratio swap.
// Optional macro JTFRAME_CEN_STEP_EN adds a single-step input that advances a paused counter.
module jtframe_cen_ctrl #(
  parameter int unsigned W    = 11,
  parameter int unsigned NUM0 = 105,
  parameter int unsigned DEN0 = 1408
) (
  input  logic                clk,
  input  logic                rst_n,
  jtframe_cen_ctrl_if.slave   ctrl
);

  typedef enum logic [1:0] {StIdle, StPend, StAck, StWait} state_e;

  state_e       r_state;
  logic [W-1:0] r_num, r_den, r_sh_num, r_sh_den;
  logic [W:0]   r_cnt;
  logic         r_alt, r_cen, r_cen_half, r_ack, r_err, r_busy;

  logic         w_adv, w_corrupt, w_cross, w_apply, w_bad_req, w_bad_sh;
  logic [W+1:0] w_cnt_ext, w_sum, w_lim;
  logic [W:0]   w_cnt_nx;
  logic         w_alt_nx, w_cen_nx, w_half_nx;

`ifdef JTFRAME_CEN_STEP_EN
  assign w_adv = ~ctrl.pause | ctrl.step;
`else
  assign w_adv = ~ctrl.pause;
`endif

  // Two extra bits keep cnt+num exact even when cnt holds a corrupt value.
  assign w_cnt_ext = {1'b0, r_cnt};
  assign w_sum     = w_cnt_ext + {2'b0, r_num};
  assign w_lim     = {2'b0, r_num} + {2'b0, r_den};
  assign w_corrupt = w_cnt_ext >= w_lim;
  assign w_cross   = w_sum >= {2'b0, r_den};

  always_comb begin
    w_cnt_nx  = r_cnt;
    w_alt_nx  = r_alt;
    w_cen_nx  = 1'b0;
    w_half_nx = 1'b0;
    if (w_adv) begin
      if (w_corrupt) begin
        w_cnt_nx  = '0;
        w_alt_nx  = 1'b0;
        w_cen_nx  = 1'b1;
        w_half_nx = 1'b1;
      end else if (w_cross) begin
        w_cnt_nx  = (W+1)'(w_sum - {2'b0, r_den});
        w_alt_nx  = ~r_alt;
        w_cen_nx  = 1'b1;
        w_half_nx = r_alt;
      end else begin
        w_cnt_nx  = w_sum[W:0];
      end
    end
  end

  assign w_bad_req = (ctrl.cfg_num == '0) || (ctrl.cfg_num > ctrl.cfg_den);
  assign w_bad_sh  = (r_sh_num == '0) || (r_sh_num > r_sh_den);
  // Swap only on a pulse boundary (or while paused) so no cen gap is ever shortened.
  assign w_apply   = (r_state == StPend) && (w_cen_nx || ctrl.pause);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_num      <= W'(NUM0);
      r_den      <= W'(DEN0);
      r_sh_num   <= '0;
      r_sh_den   <= '0;
      r_cnt      <= '0;
      r_alt      <= 1'b0;
      r_cen      <= 1'b0;
      r_cen_half <= 1'b0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nx;
      r_alt      <= w_alt_nx;
      r_cen      <= w_cen_nx;
      r_cen_half <= w_half_nx;
      r_ack      <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (ctrl.cfg_req) begin
            r_sh_num <= ctrl.cfg_num;
            r_sh_den <= ctrl.cfg_den;
            if (w_bad_req) begin
              r_state <= StAck;
            end else begin
              r_busy  <= 1'b1;
              r_state <= StPend;
            end
          end
        end
        StPend: begin
          if (w_apply) begin
            r_num   <= r_sh_num;
            r_den   <= r_sh_den;
            r_cnt   <= '0;
            r_alt   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= StAck;
          end
        end
        StAck: begin
          r_ack   <= 1'b1;
          r_err   <= w_bad_sh;
          r_state <= StWait;
        end
        StWait: begin
          if (!ctrl.cfg_req) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ctrl.cen      = r_cen;
  assign ctrl.cen_half = r_cen_half;
  assign ctrl.cfg_ack  = r_ack;
  assign ctrl.cfg_err  = r_err;
  assign ctrl.busy     = r_busy;

endmodule

// File: tb/tb_jtframe_cen_ctrl.sv
// Randomized bench for jtframe_cen_ctrl: a cycle model built from the ratio rules is compared
// against the DUT on every cycle, plus directed literal checks of cadence and handshake timing.
module tb_jtframe_cen_ctrl;
  localparam int W = 11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jtframe_cen_ctrl_if #(.W(W)) bus ();

  jtframe_cen_ctrl #(.W(W), .NUM0(105), .DEN0(1408)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  bit inj     = 1'b0;

  // Behavioural model: integer phase accumulator, pulse counter for the half-rate output.
  int m_num, m_den, m_cnt, m_pulses, m_sh_num, m_sh_den;
  bit m_cen, m_half, m_ack, m_err, m_busy;
  bit m_pending, m_ack_due, m_err_due, m_armed, m_release;

  always @(posedge clk or negedge rst_n) begin : model
    int c, p;
    bit adv, cen, half, a_due, e_due;
    if (!rst_n) begin
      m_num <= 105; m_den <= 1408; m_cnt <= 0; m_pulses <= 0;
      m_sh_num <= 0; m_sh_den <= 0;
      m_cen <= 0; m_half <= 0; m_ack <= 0; m_err <= 0; m_busy <= 0;
      m_pending <= 0; m_ack_due <= 0; m_err_due <= 0; m_armed <= 1; m_release <= 0;
    end else begin
      c = inj ? 2000 : m_cnt;
      p = m_pulses;
      cen = 0; half = 0; a_due = 0; e_due = 0;
`ifdef JTFRAME_CEN_STEP_EN
      adv = !bus.pause || bus.step;
`else
      adv = !bus.pause;
`endif
      if (adv) begin
        if (c >= m_num + m_den) begin
          c = 0; p = 0; cen = 1; half = 1;
        end else begin
          c = c + m_num;
          if (c >= m_den) begin
            c = c - m_den; p = p + 1; cen = 1; half = (p % 2 == 0);
          end
        end
      end
      m_ack <= m_ack_due;
      if (m_ack_due) begin
        m_err <= m_err_due;
        m_release <= 1;
      end
      if (m_release && !bus.cfg_req) begin
        m_release <= 0;
        m_armed <= 1;
      end
      if (m_pending && (cen || bus.pause)) begin
        m_num <= m_sh_num; m_den <= m_sh_den;
        c = 0; p = 0;
        m_pending <= 0; m_busy <= 0; a_due = 1; e_due = 0;
      end else if (m_armed && bus.cfg_req) begin
        m_armed <= 0;
        m_sh_num <= int'(bus.cfg_num);
        m_sh_den <= int'(bus.cfg_den);
        if (bus.cfg_num == 0 || bus.cfg_num > bus.cfg_den) begin
          a_due = 1; e_due = 1;
        end else begin
          m_pending <= 1; m_busy <= 1;
        end
      end
      m_ack_due <= a_due;
      m_err_due <= e_due;
      m_cnt <= c; m_pulses <= p; m_cen <= cen; m_half <= half;
    end
  end

  task automatic cmp(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      cmp("cen", bus.cen, m_cen);
      cmp("cen_half", bus.cen_half, m_half);
      cmp("cfg_ack", bus.cfg_ack, m_ack);
      cmp("cfg_err", bus.cfg_err, m_err);
      cmp("busy", bus.busy, m_busy);
    end
  endtask

  // Hold a request until ack; reports latency, busy activity and whether cen preceded ack.
  task automatic do_req(input int n, input int d, input bit rnd_pause,
                        output int cycles, output bit saw_busy, output bit cen_before);
    bit prev_cen = 0;
    bit got = 0;
    saw_busy = 0; cen_before = 0; cycles = 0;
    bus.cfg_num = W'(n);
    bus.cfg_den = W'(d);
    bus.cfg_req = 1'b1;
    for (int k = 0; k < 3000 && !got; k++) begin
      bus.pause = rnd_pause ? ($urandom % 6 == 0) : 1'b0;
      tick();
      cycles++;
      if (bus.busy) saw_busy = 1;
      if (bus.cfg_ack) begin
        got = 1;
        cen_before = prev_cen;
      end
      prev_cen = bus.cen;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout @%0t: got no cfg_ack, expected one within 3000 cycles", $time);
    end
    bus.cfg_req = 1'b0;
    bus.pause = 1'b0;
  endtask

  initial begin
    int cyc, cnt_cen, cnt_half, first, last, gmin, gmax, n, d, r;
    bit sb, cb, stop;
    bus.cfg_num = '0; bus.cfg_den = '0; bus.cfg_req = 1'b0; bus.pause = 1'b0;
`ifdef JTFRAME_CEN_STEP_EN
    bus.step = 1'b0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    tick(); tick();
    cmp("rst_cen", bus.cen, 1'b0);
    cmp("rst_cen_half", bus.cen_half, 1'b0);
    cmp("rst_ack", bus.cfg_ack, 1'b0);
    cmp("rst_err", bus.cfg_err, 1'b0);
    cmp("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;

    // Default ratio 105/1408 over one full period.
    cnt_cen = 0; cnt_half = 0; first = -1; last = -1; gmin = 99999; gmax = 0;
    for (int k = 1; k <= 1408; k++) begin
      tick();
      if (bus.cen_half) cnt_half++;
      if (bus.cen) begin
        cnt_cen++;
        if (first < 0) first = k;
        if (last > 0) begin
          if (k - last < gmin) gmin = k - last;
          if (k - last > gmax) gmax = k - last;
        end
        last = k;
      end
    end
    chk_int("first_cen_cycle", first, 14);
    chk_int("cen_per_1408", cnt_cen, 105);
    chk_int("half_per_1408", cnt_half, 52);
    chk_int("gap_min", gmin, 13);
    chk_int("gap_max", gmax, 14);

    // 1/4 swap: ack one cycle after the applying cen, then every 4th cycle.
    do_req(1, 4, 0, cyc, sb, cb);
    chk_int("q14_busy_seen", int'(sb), 1);
    chk_int("q14_cen_before_ack", int'(cb), 1);
    cnt_cen = 0; cnt_half = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      if (bus.cen) cnt_cen++;
      if (bus.cen_half) cnt_half++;
    end
    chk_int("q14_cen_in_32", cnt_cen, 8);
    chk_int("q14_half_in_32", cnt_half, 4);

    // Rejected request.
    do_req(0, 8, 0, cyc, sb, cb);
    chk_int("rej_latency", cyc, 2);
    chk_int("rej_err", int'(bus.cfg_err), 1);
    chk_int("rej_busy_seen", int'(sb), 0);
    repeat (12) tick();

    // Pause with 3/8.
    do_req(3, 8, 0, cyc, sb, cb);
    repeat (5) tick();
    bus.pause = 1'b1;
    cnt_cen = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bus.cen || bus.cen_half) cnt_cen++;
    end
    chk_int("pause_pulses", cnt_cen, 0);
    bus.pause = 1'b0;
    repeat (16) tick();

    // Corrupt counter injection.
    @(negedge clk);
    force dut.r_cnt = 12'd2000;
    inj = 1'b1;
    #1 release dut.r_cnt;
    tick();
    inj = 1'b0;
    chk_int("corrupt_cen", int'(bus.cen), 1);
    chk_int("corrupt_half", int'(bus.cen_half), 1);
    repeat (24) tick();

    // Reset while a request is pending; the held request is re-sampled afterwards.
    do_req(1, 40, 0, cyc, sb, cb);
    repeat (3) tick();
    bus.cfg_num = W'(7); bus.cfg_den = W'(9); bus.cfg_req = 1'b1;
    stop = 0;
    for (int k = 0; k < 10 && !stop; k++) begin
      tick();
      if (bus.busy) stop = 1;
    end
    chk_int("pend_busy_before_rst", int'(bus.busy), 1);
    rst_n = 1'b0;
    cnt_cen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.cfg_ack || bus.busy) cnt_cen++;
    end
    chk_int("rst_abort_ack_busy", cnt_cen, 0);
    rst_n = 1'b1;
    first = -1; stop = 0;
    for (int k = 1; k < 100 && !stop; k++) begin
      tick();
      if (bus.cen && first < 0) first = k;
      if (bus.cfg_ack) stop = 1;
    end
    chk_int("post_rst_first_cen", first, 14);
    bus.cfg_req = 1'b0;
    repeat (20) tick();

    // Randomized requests with random pause activity.
    for (int it = 0; it < 30; it++) begin
      d = $urandom_range(1, 40);
      r = $urandom % 8;
      if (r == 0) n = 0;
      else if (r == 1) n = d + 1;
      else if (r == 2) n = d;
      else n = $urandom_range(1, d);
      do_req(n, d, ($urandom % 2) == 1, cyc, sb, cb);
      r = $urandom_range(0, 40);
      for (int k = 0; k < r; k++) begin
        bus.pause = ($urandom % 5 == 0);
        tick();
      end
      bus.pause = 1'b0;
    end
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jtframe_cen_ctrl.md
Name: jtframe_cen_ctrl

Overview:
Runtime-programmable fractional clock-enable generator and scheduler for the 48 MHz domain. It produces cen pulses at an average rate of clk*num/den, plus a half-rate cen_half. It also has a req/ack configuration handshake that swaps the ratio only at a pulse boundary, so downstream cores never see a short or doubled cen gap. It also supports pause/hold, and recovers automatically from a corrupted counter. It is used where the CPU or sound cen rate is chosen at run time (turbo, region clocks, debug slowdown), instead of the fixed-ratio generators.

Parameters:
W, 11, width of counter, numerator and denominator
NUM0, 105, numerator loaded at reset
DEN0, 1408, denominator loaded at reset (NUM0/DEN0 gives 3.579545 MHz from 48 MHz)

Ports:
clk       input   1  system clock, 48 MHz
rst_n     input   1  asynchronous active-low reset
cfg_num   input   W  requested numerator, sampled on cfg_req
cfg_den   input   W  requested denominator, sampled on cfg_req
cfg_req   input   1  level request; held high until cfg_ack is seen
cfg_ack   output  1  one-cycle acknowledge pulse
cfg_err   output  1  valid with cfg_ack; 1 = request rejected
pause     input   1  hold counter, suppress all pulses
cen       output  1  fractional clock enable
cen_half  output  1  every second cen pulse
busy      output  1  request latched, not yet applied

Behaviour:
- Reset (async, rst_n=0):
  - num=NUM0, den=DEN0, cnt=0, alt=0.
  - cen=0, cen_half=0, cfg_ack=0, cfg_err=0, busy=0.
  - FSM=IDLE. The shadow num/den registers are cleared.
- Counter arithmetic (W+1 bits, no overflow):
  - next = cnt+num.
  - If cnt >= num+den (corrupt): cnt<=0, alt<=0, cen<=1, cen_half<=1.
  - Else if next >= den: cnt<=next-den, cen<=1, alt<=~alt, and cen_half<=1 only if alt was 1.
  - Else: cnt<=next, cen<=0, cen_half<=0.
- All outputs are registered; cen rises on the edge where the threshold is crossed.
- pause=1: cnt and alt hold, cen=cen_half=0 from the next edge. Deasserting pause resumes from the held cnt with no catch-up burst.
- Config FSM:
  - IDLE: when cfg_req=1, latch cfg_num/cfg_den into the shadow registers.
    - If cfg_num==0 or cfg_num>cfg_den, go to ACK with err=1.
    - Otherwise go to PEND, busy=1.
  - PEND: apply on the first cycle where the counter logic asserts cen, or on any cycle with pause=1.
    - Apply means: num/den <= shadow, cnt <= 0, alt <= 0.
    - The pulse on the apply cycle is still emitted.
    - Go to ACK, busy=0.
  - ACK: cfg_ack=1 for exactly one cycle; cfg_err shows the outcome and holds until the next ack. Go to WAIT.
  - WAIT: stay until cfg_req=0, then go to IDLE. A request held high is never re-sampled.
- Boundary cases:
  - Request in the same cycle as a cen pulse: it is latched that cycle and applied at the next pulse, never the current one.
  - num==den: cen is high on every cycle, and cen_half on every second cycle.
  - Since 1<=num<=den, the apply wait in PEND is bounded by ceil(den/num) cycles.
  - rst_n asserted mid-handshake: it aborts to IDLE with NUM0/DEN0 restored. A still-high cfg_req is re-sampled after reset.

Optional Feature:
JTFRAME_CEN_STEP_EN
- Adds input port step (1 bit).
- While pause=1, a step=1 cycle advances the counter exactly once, using the normal arithmetic. It may emit cen/cen_half, and it is a valid PEND apply point.
- step is ignored when pause=0.
- Without the macro, the port does not exist and a paused block never advances.

Test Plan:
- Release reset with NUM0=105, DEN0=1408 -> exactly 105 cen and 52 or 53 cen_half in any 1408-cycle window. Gaps are 13 or 14 cycles, never 0.
- Request num=1, den=4 mid-run -> busy until the next cen. cfg_ack follows it one cycle later. From then on cen fires every 4th cycle, first 4 cycles after apply, and cen_half every 8.
- Request num=0, den=8 -> cfg_ack one cycle later with cfg_err=1, busy never set, cen pattern unchanged.
- pause=1 for 50 cycles with num=3, den=8 -> no cen during the pause. After release the next cen comes at the cycle count implied by the held cnt.
- Force cnt corrupt (cnt=2000) -> next edge gives cen=1 and cen_half=1, cnt=0, and normal cadence afterwards.
- Pull rst_n low while in PEND -> FSM goes to IDLE, busy=0, ratio back to 105/1408, and no cfg_ack is generated.
